xpyxmy_sched: RTL and testbench

- Round-robin scheduler sharing one (X+Y)*(X-Y) datapath between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, holds operands on the datapath and pulses its load, waits a fixed datapath latency, then returns the 32-bit result tagged with the requester id.
- Sits between client blocks and the single xpyxmy datapath instance; the datapath stays outside this block.

---
 rtl/xpyxmy_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/xpyxmy_sched.sv | 117 +++++++++++
 tb/tb_xpyxmy_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpyxmy_pkg.sv
// rtl/xpyxmy_pkg.sv - shared widths and FSM state type for the xpyxmy scheduler
package xpyxmy_pkg;

  localparam int DW = 16;
  localparam int OW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts just after ptr
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  // Pick the first active request strictly after ptr, wrapping modulo NREQ
  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand[IDW-1:0]]) begin
        any                  = 1'b1;
        gnt[cand[IDW-1:0]]   = 1'b1;
        gnt_idx              = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/xpyxmy_sched.sv
// rtl/xpyxmy_sched.sv - round-robin scheduler for a shared (X+Y)*(X-Y) datapath; optional stats via XPYXMY_SCHED_STATS_EN
module xpyxmy_sched
  import xpyxmy_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DP_LAT = 2,
  parameter int IDW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_x,
  input  logic [NREQ*DW-1:0]   req_y,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [OW-1:0]        resp_o,
  output logic [IDW-1:0]       resp_id,
  output logic [DW-1:0]        dp_x,
  output logic [DW-1:0]        dp_y,
  output logic                 dp_load,
  input  logic [OW-1:0]        dp_o
`ifdef XPYXMY_SCHED_STATS_EN
  ,
  output logic [15:0]          op_cnt,
  output logic                 busy
`endif
);

  localparam int CW = $clog2(DP_LAT + 1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any;
  logic [DW-1:0]   sel_x;
  logic [DW-1:0]   sel_y;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign sel_x = req_x[DW*gnt_idx +: DW];
  assign sel_y = req_y[DW*gnt_idx +: DW];

  // Grants are only offered while idle; the datapath is busy otherwise
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign resp_id   = id_q;

  // Scheduler FSM: accept, pulse load, wait out the datapath latency, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      id_q       <= '0;
      cnt        <= '0;
      dp_x       <= '0;
      dp_y       <= '0;
      dp_load    <= 1'b0;
      resp_valid <= 1'b0;
      resp_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            dp_x    <= sel_x;
            dp_y    <= sel_y;
            id_q    <= gnt_idx;
            dp_load <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          dp_load <= 1'b0;
          cnt     <= CW'(DP_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            resp_o     <= dp_o;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr        <= id_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XPYXMY_SCHED_STATS_EN
  // Completed-response counter, wraps at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_cnt <= '0;
    else if (state == RESP && resp_ready)
      op_cnt <= op_cnt + 16'd1;
  end

  assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_xpyxmy_sched.sv
// tb/tb_xpyxmy_sched.sv - scoreboard bench for xpyxmy_sched with a behavioural datapath
module tb_xpyxmy_sched;
  import xpyxmy_pkg::*;

  localparam int NREQ   = 4;
  localparam int DP_LAT = 2;
  localparam int IDW    = 2;

  typedef struct {
    int id;
    int res;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*16-1:0]  req_x;
  logic [NREQ*16-1:0]  req_y;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [31:0]         resp_o;
  logic [IDW-1:0]      resp_id;
  logic [15:0]         dp_x;
  logic [15:0]         dp_y;
  logic                dp_load;
  logic [31:0]         dp_o;
`ifdef XPYXMY_SCHED_STATS_EN
  logic [15:0]         op_cnt;
  logic                busy;
`endif

  logic signed [15:0]  xs [NREQ];
  logic signed [15:0]  ys [NREQ];
  exp_t                exp_q [$];
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  cyc = 0;
  int                  pipe [DP_LAT];

  xpyxmy_sched #(.NREQ(NREQ), .DP_LAT(DP_LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_o     (resp_o),
    .resp_id    (resp_id),
    .dp_x       (dp_x),
    .dp_y       (dp_y),
    .dp_load    (dp_load),
    .dp_o       (dp_o)
`ifdef XPYXMY_SCHED_STATS_EN
    ,
    .op_cnt     (op_cnt),
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_f(input logic signed [15:0] x, input logic signed [15:0] y);
    int xi;
    int yi;
    xi = x;
    yi = y;
    return xi * xi - yi * yi;
  endfunction

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[16*i +: 16] = xs[i];
      req_y[16*i +: 16] = ys[i];
    end
  end

  // Behavioural datapath: captured on load, result after DP_LAT stages
  always @(posedge clk) begin
    if (dp_load) pipe[0] <= exp_f(dp_x, dp_y);
    for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_o = pipe[DP_LAT-1];

  // Scoreboard push: a request handshake visible at negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i])
          exp_q.push_back('{i, exp_f(xs[i], ys[i])});
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req_hs(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp_hs(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin xs[i] = '0; ys[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    vectors++; if (resp_valid !== 1'b0 || dp_load !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got rv=%b ld=%b want 0 0", resp_valid, dp_load); end
    vectors++; if (resp_o !== 32'd0 || resp_id !== 2'd0) begin miscompares++; $display("FAIL reset_resp got o=%0h id=%0d want 0 0", resp_o, resp_id); end
    vectors++; if (dp_x !== 16'd0 || dp_y !== 16'd0) begin miscompares++; $display("FAIL reset_dp got x=%0h y=%0h want 0 0", dp_x, dp_y); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xs[0] = 16'sd10; ys[0] = 16'sd3; req_valid = 4'b0001;
    @(negedge clk);
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL first_grant got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    vectors++; if (dp_load !== 1'b1) begin miscompares++; $display("FAIL load_pulse got=%b want=1", dp_load); end
    vectors++; if (dp_x !== 16'd10 || dp_y !== 16'd3) begin miscompares++; $display("FAIL load_operands got x=%0d y=%0d want 10 3", dp_x, dp_y); end
    @(negedge clk);
    vectors++; if (dp_load !== 1'b0) begin miscompares++; $display("FAIL load_one_cycle got=%b want=0", dp_load); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_early got=%b want=0", resp_valid); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL resp_latency got=%b want=1", resp_valid); end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL first_resp_sb got=empty want=1 entry");
    end else begin
      e = exp_q.pop_front();
      if (resp_o !== e.res || resp_id !== IDW'(e.id) || e.res != 91) begin
        miscompares++; $display("FAIL first_resp got o=%0d id=%0d want o=%0d id=%0d", $signed(resp_o), resp_id, e.res, e.id);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    exp_t e;
    int n_hs;
    int n_resp;
    int last_c;
    int want;
    int id;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin xs[i] = 16'(i * 7 + 1); ys[i] = 16'(-(i * 3) - 2); end
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    n_hs = 0; n_resp = 0; last_c = 0; want = 0; id = 0;
    for (int t = 0; t < 80 && n_resp < 6; t++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rr_resp_sb got=empty want=entry");
        end else begin
          e = exp_q.pop_front();
          if (resp_o !== e.res || resp_id !== IDW'(e.id)) begin
            miscompares++; $display("FAIL rr_resp got o=%0d id=%0d want o=%0d id=%0d", $signed(resp_o), resp_id, e.res, e.id);
          end
        end
        n_resp++;
      end
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        vectors++; if (id != want || !$onehot(req_ready)) begin miscompares++; $display("FAIL rr_order got=%b want id %0d", req_ready, want); end
        if (n_hs > 0) begin
          vectors++; if (cyc - last_c != DP_LAT + 3) begin miscompares++; $display("FAIL rr_spacing got=%0d want=%0d", cyc - last_c, DP_LAT + 3); end
        end
        last_c = cyc;
        want = (want + 1) % NREQ;
        n_hs++;
        if (n_hs == 6) begin
          @(posedge clk); #1;
          req_valid = '0;
        end
      end
    end
    vectors++; if (n_resp != 6) begin miscompares++; $display("FAIL rr_timeout got=%0d responses want=6", n_resp); end
  endtask

  task automatic test_signed;
    logic signed [15:0] tx [3];
    logic signed [15:0] ty [3];
    int                 tr [3];
    exp_t e;
    bit   ok;
    tx[0] = -16'sd5;   ty[0] = 16'sd7;     tr[0] = 2;
    tx[1] = -16'sd32768; ty[1] = 16'sd0;   tr[1] = 1;
    tx[2] = 16'sd32767; ty[2] = -16'sd32768; tr[2] = 3;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      xs[tr[k]] = tx[k]; ys[tr[k]] = ty[k];
      req_valid = NREQ'(1) << tr[k];
      wait_req_hs(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL signed_grant_timeout got=none want=id %0d", tr[k]); end
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp_hs(ok);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        miscompares++; $display("FAIL signed_resp_timeout got=ok %0b q %0d want=1 1", ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (resp_o !== e.res || resp_id !== IDW'(e.id)) begin
          miscompares++; $display("FAIL signed_resp got o=%0d id=%0d want o=%0d id=%0d", $signed(resp_o), resp_id, e.res, e.id);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    exp_t cur;
    bit   ok;
    bit   seen;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin xs[i] = 16'(100 + i); ys[i] = 16'(i); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_req_hs(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_grant_timeout got=none want=id 1"); end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL bp_resp_timeout got=none want=resp_valid"); end
    cur = '{-1, 0};
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    for (int t = 0; t < 10; t++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_o !== cur.res || resp_id !== IDW'(cur.id) || req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL bp_stall got rv=%b o=%0d id=%0d rdy=%b want 1 %0d %0d 0000", resp_valid, $signed(resp_o), resp_id, req_ready, cur.res, cur.id);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_next_grant got rv=%b rdy=%b want 0 0100", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp_hs(ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++; $display("FAIL bp_drain_timeout got=ok %0b want=1", ok);
    end else begin
      e = exp_q.pop_front();
      if (resp_o !== e.res || resp_id !== 2'd2) begin
        miscompares++; $display("FAIL bp_drain got o=%0d id=%0d want o=%0d id=2", $signed(resp_o), resp_id, e.res);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait;
    exp_t e;
    bit   ok;
    bit   rose;
    resp_ready = 1'b1;
    xs[3] = 16'sd9; ys[3] = 16'sd4;
    req_valid = 4'b1000;
    wait_req_hs(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rw_grant_timeout got=none want=id 3"); end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (dp_x !== 16'd0 || dp_load !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rw_async_clear got x=%0h ld=%b rv=%b want 0 0 0", dp_x, dp_load, resp_valid); end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rose = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (resp_valid) rose = 1'b1;
    end
    vectors++; if (rose) begin miscompares++; $display("FAIL rw_lost_request got=resp_valid want=none"); end
    @(posedge clk); #1;
    xs[0] = 16'sd6; ys[0] = 16'sd6; xs[2] = 16'sd1; ys[2] = 16'sd2;
    req_valid = 4'b0101;
    @(negedge clk);
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rw_first_grant got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp_hs(ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++; $display("FAIL rw_resp_timeout got=ok %0b want=1", ok);
    end else begin
      e = exp_q.pop_front();
      if (resp_o !== e.res || resp_id !== 2'd0) begin
        miscompares++; $display("FAIL rw_resp got o=%0d id=%0d want o=%0d id=0", $signed(resp_o), resp_id, e.res);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop_valid;
    resp_ready = 1'b0;
    xs[1] = 16'sd77; ys[1] = 16'sd11;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    #2;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL drop_offer got=%b want=0010", req_ready); end
    #1;
    req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (dp_load !== 1'b0 || dp_x !== 16'd6 || dp_y !== 16'd6 || resp_valid !== 1'b0) begin
        miscompares++; $display("FAIL drop_no_effect got ld=%b x=%0d y=%0d rv=%b want 0 6 6 0", dp_load, dp_x, dp_y, resp_valid);
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL drop_sb got=%0d want=0", exp_q.size()); end
  endtask

`ifdef XPYXMY_SCHED_STATS_EN
  task automatic test_stats;
    exp_t e;
    bit   ok;
    do_reset();
    @(negedge clk);
    vectors++; if (op_cnt !== 16'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL stats_reset got cnt=%0d busy=%b want 0 0", op_cnt, busy); end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        force dut.op_cnt = 16'hFFFF;
        #1;
        release dut.op_cnt;
      end
      @(posedge clk); #1;
      xs[0] = 16'(k + 2); ys[0] = 16'(k);
      req_valid = 4'b0001;
      wait_req_hs(ok);
      vectors++; if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL stats_idle got ok=%0b busy=%b want 1 0", ok, busy); end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stats_busy got=%b want=1", busy); end
      wait_resp_hs(ok);
      vectors++; if (!ok || busy !== 1'b1) begin miscompares++; $display("FAIL stats_busy_resp got ok=%0b busy=%b want 1 1", ok, busy); end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stats_unbusy got=%b want=0", busy); end
      if (k == 2) begin
        vectors++; if (op_cnt !== 16'd3) begin miscompares++; $display("FAIL stats_count got=%0d want=3", op_cnt); end
      end
    end
    vectors++; if (op_cnt !== 16'd0) begin miscompares++; $display("FAIL stats_wrap got=%0h want=0", op_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_signed();
    test_backpressure();
    test_reset_in_wait();
    test_drop_valid();
`ifdef XPYXMY_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
